// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencers (XOR, AND, OR, ADD).
//   ALU_WIDTH      : default datapath width of the combinational ALU units
//   BYTES_PER_WORD : number of byte lanes in one ALU_WIDTH operand
//   state_t        : sequencer states, operand load through result hold
//   cnt_width()    : width of a byte-lane counter for a given lane count
package alu_pkg;

  localparam int unsigned ALU_WIDTH      = 32;
  localparam int unsigned BYTES_PER_WORD = ALU_WIDTH / 8;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    HOLD
  } state_t;

  // A single-lane word still needs a 1-bit counter to form a legal vector.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/alu_operand_loader_byte_shift_loader.sv
// Byte-lane operand register for one ALU operand.
//   clk, rst : clock and synchronous active-high reset (clears word and counter)
//   en       : write data into the lane selected by the internal counter
//   data     : byte to write
//   word     : assembled operand, lanes filled little-endian
//   last     : the counter points at the top lane (next write completes the word)
//   partial  : at least one lane of the current word has been written
module byte_shift_loader
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] word,
  output logic             last,
  output logic             partial
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CW     = cnt_width(NBYTES);

  logic [CW-1:0] cnt;

  assign last    = (cnt == CW'(NBYTES - 1));
  assign partial = (cnt != '0);

  // Lanes not yet rewritten keep the previous transaction's bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (cnt == CW'(i)) begin
          word[i*8 +: 8] <= data;
        end
      end
      // Explicit clear after the top lane so non-power-of-two lane counts work.
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Clocked front end for the 32-bit combinational XOR unit.
// Collects operand A then operand B as little-endian bytes from a valid/ready
// stream, drives them on registered outputs, waits SETTLE_CYCLES for the XOR
// unit, then holds the captured result on a valid/ready output.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : byte stream handshake, in_data carries the byte
//   op_a, op_b           : registered operands into the XOR unit
//   alu_result           : combinational XOR output (op_a ^ op_b)
//   res_valid/res_ready  : result handshake, res_data carries the result
//   busy                 : transaction in progress (not idle in LOAD_A)
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = ALU_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam int unsigned SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  if ((WIDTH == 0) || (WIDTH % 8 != 0)) begin : g_bad_width
    $error("alu_operand_loader: WIDTH must be a non-zero multiple of 8");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_operand_loader: SETTLE_CYCLES must be at least 1");
  end

  state_t        state, state_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic          a_en, b_en;
  logic          a_last, b_last;
  logic          a_partial, b_partial;
  logic          capture, handoff;

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign a_en     = (state == LOAD_A) && in_valid;
  assign b_en     = (state == LOAD_B) && in_valid;
  // b_partial is always clear in LOAD_A, so only a_partial matters there.
  assign busy     = (state != LOAD_A) || a_partial || b_partial;

  byte_shift_loader #(.WIDTH(WIDTH)) u_load_a (
    .clk     (clk),
    .rst     (rst),
    .en      (a_en),
    .data    (in_data),
    .word    (op_a),
    .last    (a_last),
    .partial (a_partial)
  );

  byte_shift_loader #(.WIDTH(WIDTH)) u_load_b (
    .clk     (clk),
    .rst     (rst),
    .en      (b_en),
    .data    (in_data),
    .word    (op_b),
    .last    (b_last),
    .partial (b_partial)
  );

  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    capture   = 1'b0;
    handoff   = 1'b0;
    unique case (state)
      LOAD_A: begin
        if (a_en && a_last) begin
          state_nx = LOAD_B;
        end
      end
      LOAD_B: begin
        if (b_en && b_last) begin
          state_nx  = SETTLE;
          settle_nx = SW'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        // Capture on the edge where the count reaches 1, giving exactly
        // SETTLE_CYCLES edges from the last B byte to res_valid.
        if (settle_cnt == SW'(1)) begin
          capture   = 1'b1;
          state_nx  = HOLD;
          settle_nx = '0;
        end else begin
          settle_nx = settle_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          handoff  = 1'b1;
          state_nx = LOAD_A;
        end
      end
      default: begin
        state_nx  = LOAD_A;
        settle_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_A;
      settle_cnt <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
      if (capture) begin
        res_data  <= alu_result;
        res_valid <= 1'b1;
      end else if (handoff) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

  localparam int unsigned W  = 32;
  localparam int unsigned NB = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build (SETTLE_CYCLES = 1)
  logic         rst, in_valid, in_ready, res_valid, res_ready, busy;
  logic [7:0]   in_data;
  logic [W-1:0] op_a, op_b, alu_result, res_data;
  assign alu_result = op_a ^ op_b;

  alu_operand_loader #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .alu_result(alu_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // SETTLE_CYCLES = 4 build
  logic         rst4, in_valid4, in_ready4, res_valid4, res_ready4, busy4;
  logic [7:0]   in_data4;
  logic [W-1:0] op_a4, op_b4, alu_result4, res_data4;
  assign alu_result4 = op_a4 ^ op_b4;

  alu_operand_loader #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .alu_result(alu_result4), .res_valid(res_valid4),
    .res_ready(res_ready4), .res_data(res_data4), .busy(busy4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int waits = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bit done;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    done     = 1'b0;
    if (!in_ready) waits++;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int unsigned maxgap);
    for (int unsigned i = 0; i < NB; i++)
      send_byte(w[i*8 +: 8], $urandom_range(maxgap, 0));
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp += 6;
    if (op_a !== '0)      begin n_err++; $display("FAIL reset_op_a: got %h, required 0", op_a); end
    if (op_b !== '0)      begin n_err++; $display("FAIL reset_op_b: got %h, required 0", op_b); end
    if (res_data !== '0)  begin n_err++; $display("FAIL reset_res_data: got %h, required 0", res_data); end
    if (res_valid !== 0)  begin n_err++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
    if (in_ready !== 1)   begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (busy !== 0)       begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    send_word(32'h12345678, 0);
    send_word(32'hFFFF0000, 0);
    n_cmp += 5;
    if (op_a !== 32'h12345678) begin n_err++; $display("FAIL basic_op_a: got %h, required 12345678", op_a); end
    if (op_b !== 32'hFFFF0000) begin n_err++; $display("FAIL basic_op_b: got %h, required ffff0000", op_b); end
    if (res_valid !== 0) begin n_err++; $display("FAIL basic_early_valid: got %b, required 0", res_valid); end
    if (in_ready !== 0)  begin n_err++; $display("FAIL basic_settle_ready: got %b, required 0", in_ready); end
    if (busy !== 1)      begin n_err++; $display("FAIL basic_settle_busy: got %b, required 1", busy); end
    tick();
    n_cmp += 2;
    if (res_valid !== 1) begin n_err++; $display("FAIL basic_valid: got %b, required 1", res_valid); end
    if (res_data !== 32'hEDCB5678) begin n_err++; $display("FAIL basic_data: got %h, required edcb5678", res_data); end
    tick();
    n_cmp += 3;
    if (res_valid !== 0) begin n_err++; $display("FAIL basic_one_cycle: got %b, required 0", res_valid); end
    if (in_ready !== 1)  begin n_err++; $display("FAIL basic_ready_back: got %b, required 1", in_ready); end
    if (busy !== 0)      begin n_err++; $display("FAIL basic_idle: got %b, required 0", busy); end
  endtask

  task automatic test_gaps();
    res_ready = 1'b1;
    waits = 0;
    send_word(32'hDEADBEEF, 3);
    send_word(32'hDEADBEEF, 3);
    n_cmp++;
    if (waits !== 0) begin n_err++; $display("FAIL gaps_ready_drop: stalls=%0d, required 0", waits); end
    tick();
    n_cmp += 2;
    if (res_valid !== 1) begin n_err++; $display("FAIL gaps_valid: got %b, required 1", res_valid); end
    if (res_data !== '0) begin n_err++; $display("FAIL gaps_data: got %h, required 0", res_data); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    res_ready = 1'b0;
    send_word(32'hFFFFFFFF, 0);
    send_word(32'h0F0F0F0F, 0);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp += 5;
      if (res_valid !== 1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b, required 1", i, res_valid); end
      if (res_data !== 32'hF0F0F0F0) begin n_err++; $display("FAIL bp_data[%0d]: got %h, required f0f0f0f0", i, res_data); end
      if (in_ready !== 0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b, required 0", i, in_ready); end
      if (op_a !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bp_op_a[%0d]: got %h, required ffffffff", i, op_a); end
      if (op_b !== 32'h0F0F0F0F) begin n_err++; $display("FAIL bp_op_b[%0d]: got %h, required 0f0f0f0f", i, op_b); end
      in_data = 8'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    n_cmp += 2;
    if (res_valid !== 0) begin n_err++; $display("FAIL bp_release: got %b, required 0", res_valid); end
    if (in_ready !== 1)  begin n_err++; $display("FAIL bp_ready_back: got %b, required 1", in_ready); end
    a = $urandom; b = $urandom;
    send_word(a, 0);
    send_word(b, 0);
    tick();
    n_cmp += 2;
    if (res_valid !== 1)    begin n_err++; $display("FAIL bp_next_valid: got %b, required 1", res_valid); end
    if (res_data !== (a ^ b)) begin n_err++; $display("FAIL bp_next_data: got %h, required %h", res_data, a ^ b); end
    tick();
  endtask

  task automatic test_reset_midload();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0);
    n_cmp++;
    if (busy !== 1) begin n_err++; $display("FAIL mid_busy: got %b, required 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 6;
    if (op_a !== '0)     begin n_err++; $display("FAIL mid_op_a: got %h, required 0", op_a); end
    if (op_b !== '0)     begin n_err++; $display("FAIL mid_op_b: got %h, required 0", op_b); end
    if (res_data !== '0) begin n_err++; $display("FAIL mid_res_data: got %h, required 0", res_data); end
    if (res_valid !== 0) begin n_err++; $display("FAIL mid_res_valid: got %b, required 0", res_valid); end
    if (in_ready !== 1)  begin n_err++; $display("FAIL mid_in_ready: got %b, required 1", in_ready); end
    if (busy !== 0)      begin n_err++; $display("FAIL mid_idle: got %b, required 0", busy); end
    send_word(32'h1, 0);
    send_word(32'h3, 0);
    tick();
    n_cmp += 2;
    if (res_valid !== 1)        begin n_err++; $display("FAIL mid_fresh_valid: got %b, required 1", res_valid); end
    if (res_data !== 32'h2)     begin n_err++; $display("FAIL mid_fresh_data: got %h, required 00000002", res_data); end
    tick();
  endtask

  task automatic test_reset_settle_hold();
    res_ready = 1'b1;
    send_word($urandom, 0);
    send_word($urandom, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 3;
    if (res_valid !== 0) begin n_err++; $display("FAIL settle_rst_valid: got %b, required 0", res_valid); end
    if (busy !== 0)      begin n_err++; $display("FAIL settle_rst_busy: got %b, required 0", busy); end
    if (in_ready !== 1)  begin n_err++; $display("FAIL settle_rst_ready: got %b, required 1", in_ready); end
    tick(); tick();
    n_cmp++;
    if (res_valid !== 0) begin n_err++; $display("FAIL settle_rst_no_result: got %b, required 0", res_valid); end
    res_ready = 1'b0;
    send_word(32'h5A5A5A5A, 0);
    send_word(32'h00FF00FF, 0);
    tick();
    n_cmp++;
    if (res_valid !== 1) begin n_err++; $display("FAIL hold_pre_valid: got %b, required 1", res_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 3;
    if (res_valid !== 0) begin n_err++; $display("FAIL hold_rst_valid: got %b, required 0", res_valid); end
    if (busy !== 0)      begin n_err++; $display("FAIL hold_rst_busy: got %b, required 0", busy); end
    if (res_data !== '0) begin n_err++; $display("FAIL hold_rst_data: got %h, required 0", res_data); end
  endtask

  // Reference: result = A ^ B, valid exactly one edge after the last B byte,
  // stable until the consumer takes it.
  task automatic test_random();
    logic [W-1:0] a, b, exp;
    int lat, hold;
    for (int t = 0; t < 25; t++) begin
      a = $urandom; b = $urandom; exp = a ^ b;
      res_ready = 1'($urandom_range(1, 0));
      send_word(a, 3);
      send_word(b, 3);
      lat = 0;
      while (!res_valid && lat < 10) begin tick(); lat++; end
      n_cmp += 3;
      if (lat !== 1)        begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d, required 1", t, lat); end
      if (res_data !== exp) begin n_err++; $display("FAIL rnd_data[%0d]: got %h, required %h", t, res_data, exp); end
      if (op_a !== a)       begin n_err++; $display("FAIL rnd_op_a[%0d]: got %h, required %h", t, op_a, a); end
      if (!res_ready) begin
        hold = $urandom_range(3, 0);
        repeat (hold) begin
          tick();
          n_cmp++;
          if (res_valid !== 1 || res_data !== exp) begin
            n_err++; $display("FAIL rnd_hold[%0d]: got %b/%h, required 1/%h", t, res_valid, res_data, exp);
          end
        end
        res_ready = 1'b1;
      end
      tick();
      n_cmp += 2;
      if (res_valid !== 0) begin n_err++; $display("FAIL rnd_handoff[%0d]: got %b, required 0", t, res_valid); end
      if (in_ready !== 1)  begin n_err++; $display("FAIL rnd_ready[%0d]: got %b, required 1", t, in_ready); end
      res_ready = 1'b0;
    end
  endtask

  task automatic test_settle4();
    logic [2*W-1:0] ab;
    int lat;
    ab = {32'h55555555, 32'hAAAAAAAA};
    rst4 = 1'b0; res_ready4 = 1'b1;
    for (int unsigned i = 0; i < 2 * NB; i++) begin
      in_valid4 = 1'b1;
      in_data4  = ab[i*8 +: 8];
      n_cmp++;
      if (in_ready4 !== 1) begin n_err++; $display("FAIL s4_ready[%0d]: got %b, required 1", i, in_ready4); end
      tick();
    end
    in_valid4 = 1'b0;
    lat = 0;
    while (!res_valid4 && lat < 20) begin tick(); lat++; end
    n_cmp += 2;
    if (lat !== 4)                 begin n_err++; $display("FAIL s4_latency: got %0d, required 4", lat); end
    if (res_data4 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL s4_data: got %h, required ffffffff", res_data4); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    rst4 = 1'b1; in_valid4 = 1'b0; in_data4 = '0; res_ready4 = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_reset_midload();
    test_reset_settle_hold();
    test_random();
    test_settle4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream/downstream sequencer for the 32-bit combinational XOR unit.
- Assembles operands A and B from a byte-serial valid/ready stream and drives them on registered outputs into the XOR unit.
- Waits a fixed settle time, then captures the XOR output into a result register presented on a valid/ready interface.
- Gives the combinational ALU units a clocked front end, so benches and higher levels see a handshake instead of fixed #delays.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 (elaboration-time error otherwise).
- SETTLE_CYCLES, 1, cycles between the last B byte accepted and result capture; legal range >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a byte.
- in_data  in  8  operand byte: A little-endian first (WIDTH/8 bytes), then B little-endian.
- in_ready  out  1  block accepts a byte this cycle.
- op_a  out  WIDTH  registered operand A to the XOR unit.
- op_b  out  WIDTH  registered operand B to the XOR unit.
- alu_result  in  WIDTH  combinational XOR output (op_a ^ op_b).
- res_valid  out  1  res_data holds a captured result.
- res_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  captured result.
- busy  out  1  high in any state other than LOAD_A with byte count 0.

Behaviour:
- Reset values:
  - op_a = 0, op_b = 0, res_data = 0, res_valid = 0, in_ready = 1, busy = 0.
  - State = LOAD_A, byte counter = 0, settle counter = 0.
  - Reset takes priority over everything, including mid-load, SETTLE and HOLD. A partial operand is discarded and previously loaded op values are cleared.
- Accept rule: a byte transfers on a rising edge where in_valid & in_ready. If in_ready = 0, in_valid and in_data are ignored and nothing is buffered.
- in_ready = 1 exactly in LOAD_A and LOAD_B.
- FSM transitions:
  - LOAD_A: accepted byte k writes op_a[8k+7:8k]. After the byte with k = WIDTH/8-1, go to LOAD_B and clear the counter.
  - LOAD_B: same, writing op_b. The last byte loads settle counter = SETTLE_CYCLES and goes to SETTLE.
  - SETTLE: decrement each cycle. On the edge where the counter equals 1, capture res_data <= alu_result, set res_valid = 1, go to HOLD.
  - HOLD: res_valid and res_data stable. On an edge with res_ready = 1, clear res_valid, go to LOAD_A, counter = 0.
- Latency: res_valid rises SETTLE_CYCLES edges after the edge accepting the last B byte. With the default, this is the next edge.
- Throughput: one result per 2·WIDTH/8 + SETTLE_CYCLES + 1 cycles minimum (back-to-back, res_ready held high). in_ready rises the cycle after the result handoff.
- op_a/op_b change only while their bytes load. They hold their last value through SETTLE and HOLD and into the next load; the downstream unit is only sampled in SETTLE.
- Partial operand bytes overwrite in place. Stale upper bytes from the previous transaction stay visible on op_a/op_b until overwritten. This is legal because no capture happens mid-load.
- in_valid gaps: the counter holds, with no timeout.
- res_ready asserted outside HOLD has no effect.
- No arithmetic inside the block. Widths are exact; the counter is $clog2(WIDTH/8) bits wide and wraps only via explicit clear.

Decomposition:
- Shared package alu_pkg:
  - state enum {LOAD_A, LOAD_B, SETTLE, HOLD}.
  - ALU_WIDTH = 32 and BYTES_PER_WORD = ALU_WIDTH/8.
  - Reused by sibling sequencers for the AND/OR/ADD units.
- One natural sub-module: byte_shift_loader. It takes an enable and a byte and writes the indexed byte lane with its counter and a last flag. It is instantiated twice, for A and B.
- The FSM and result register stay in the top.

Test Plan:
- Bytes 78 56 34 12 then 00 00 FF FF, no gaps, res_ready = 1 → op_a = 0x12345678, op_b = 0xFFFF0000, res_data = 0xEDCB5678, res_valid for exactly 1 cycle, one edge after the last byte.
- A = B = 0xDEADBEEF with random in_valid gaps of 0–3 cycles → res_data = 0x00000000; in_ready never drops during the load.
- res_ready held low 5 cycles after result (A = 0xFFFFFFFF, B = 0x0F0F0F0F) while in_valid = 1 with junk bytes → res_valid and res_data = 0xF0F0F0F0 stable, in_ready = 0, junk not loaded. Next result is correct after release.
- rst pulsed after 3 A bytes → all outputs return to reset values. A fresh 8-byte load (A = 1, B = 3) yields res_data = 0x00000002.
- rst pulsed during SETTLE and during HOLD → res_valid = 0 the next cycle, no result emitted, busy = 0.
- SETTLE_CYCLES = 4 build, A = 0xAAAAAAAA, B = 0x55555555 → res_valid rises exactly 4 edges after the last byte, res_data = 0xFFFFFFFF.
